bin2bcd_seq: RTL

Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") sitting directly downstream of the calculator's n-bit multiplier and adder outputs. It accepts a `width`-bit binary result on a start strobe, runs one shift per clock, and presents `digits` packed BCD digits to the display driver with a one-cycle done pulse. It spreads the conversion over `width` cycles, so the datapath stays small instead of being one long combinational cascade.

---
 rtl/calc_pkg.sv | 18 +
 rtl/bin2bcd_seq_if.sv | 28 ++
 rtl/bcd_digit_adj.sv | 18 +
 rtl/bin2bcd_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: converter FSM states, BCD digit width and
// the minimum-digit helper used to reject undersized converter instances.
package calc_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bin2bcd_state_e;

    // ceil(width * log10(2)), with log10(2) scaled by 1e5
    function automatic int unsigned bcd_digits(input int unsigned width);
        return (width * 32'd30103 + 32'd99999) / 32'd100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a binary producer and the BCD converter.
interface bin2bcd_seq_if
    import calc_pkg::*;
#(
    parameter int unsigned width  = 16,
    parameter int unsigned digits = 5
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * digits;

    logic             start_i;
    logic [width-1:0] bin_i;
    logic             busy_o;
    logic             done_o;
    logic [BCD_W-1:0] bcd_o;
    logic             sign_o;

    modport master (
        output start_i, bin_i,
        input  busy_o, done_o, bcd_o, sign_o
    );

    modport slave (
        input  start_i, bin_i,
        output busy_o, done_o, bcd_o, sign_o
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit pre-shift correction: values 5..9 get +3 so the following
// left shift carries into the next digit.
module bcd_digit_adj
    import calc_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout_c
);

    // add 3 when digit >= 5
    always_comb begin
        dout_c = din;
        if (din >= BCD_DIGIT_W'(5)) begin
            dout_c = din + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Optional feature macro: BIN2BCD_SIGNED_EN (two's complement input,
// magnitude converted, sign reported on sign_o).
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int unsigned width  = 16,
    parameter int unsigned digits = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    bin2bcd_seq_if.slave  bus
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * digits;
    localparam int unsigned CNT_W = $clog2(width + 1);
    localparam int unsigned CAT_W = BCD_W + width;

    if (digits < bcd_digits(width)) begin : g_param_err
        $error("bin2bcd_seq: digits=%0d too small for width=%0d", digits, width);
    end

    bin2bcd_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [width-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] out_q, out_d;
    logic             busy_q, done_q;
    logic             capture_c;
    logic             final_c;
    logic [width-1:0] mag_c;
    logic [BCD_W-1:0] adj_c;
    logic [CAT_W-1:0] cat_c;

    // per-digit adjust ahead of each shift
    for (genvar g = 0; g < int'(digits); g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din    (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout_c (adj_c[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // joint left shift: binary MSB enters digit 0 LSB
    always_comb begin
        cat_c = {adj_c, bin_q} << 1;
    end

`ifdef BIN2BCD_SIGNED_EN
    logic sign_pend_q;
    logic sign_q;

    // magnitude of two's complement operand; -2^(width-1) maps to 2^(width-1)
    always_comb begin
        mag_c = bus.bin_i;
        if (bus.bin_i[width-1]) begin
            mag_c = (~bus.bin_i) + width'(1);
        end
    end

    // sign captured with the operand, published with the result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sign_pend_q <= 1'b0;
            sign_q      <= 1'b0;
        end else begin
            if (capture_c) begin
                sign_pend_q <= bus.bin_i[width-1];
            end
            if (final_c) begin
                sign_q <= sign_pend_q;
            end
        end
    end

    assign bus.sign_o = sign_q;
`else
    // unsigned operand converted as-is
    always_comb begin
        mag_c = bus.bin_i;
    end

    assign bus.sign_o = 1'b0;
`endif

    // next-state and datapath update; a start seen on the DONE exit edge is
    // accepted so a held start yields one conversion every width+1 cycles
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        out_d     = out_q;
        capture_c = 1'b0;
        final_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                capture_c = bus.start_i;
            end
            SHIFT: begin
                bcd_d = cat_c[CAT_W-1:width];
                bin_d = cat_c[width-1:0];
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q == CNT_W'(1)) begin
                    final_c = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d   = IDLE;
                capture_c = bus.start_i;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (final_c) begin
            out_d = cat_c[CAT_W-1:width];
        end
        if (capture_c) begin
            bin_d   = mag_c;
            bcd_d   = '0;
            cnt_d   = CNT_W'(width);
            state_d = SHIFT;
        end
    end

    // state, datapath and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            out_q   <= out_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.bcd_o  = out_q;

endmodule
